// File: rtl/pcpu_pkg.sv
// Shared CPU pipeline constants and the fetch queue entry layout.
package pcpu_pkg;

    localparam int PC_W    = 7;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Next sequential word address; wraps at the top of the PC space.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1'b1);
    endfunction

endpackage

// File: rtl/fetch_buf_mem.sv
// Register-array storage for the fetch buffer: synchronous write, asynchronous read, no reset.
module fetch_buf_mem
    import pcpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];

    // Entry write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between fetch and decode; presents the oldest entry,
// flags full for the stall logic, and drops everything on a decode-side flush.
module fetch_buffer
    import pcpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PC_W-1:0]          PCF,
    input  logic [INSTR_W-1:0]       InstrF,
    input  logic                     PushF,
    input  logic                     StallD,
    input  logic                     FlushD,
    output logic [INSTR_W-1:0]       InstrD,
    output logic [PC_W-1:0]          PCPlus1D,
    output logic                     ValidD,
    output logic                     BufFullF,
    output logic [$clog2(DEPTH):0]   CountF
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      rd_ptr_r;
    logic [AW-1:0]      wr_ptr_r;
    logic [CW-1:0]      count_r;
    logic               valid_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               we_s;
    fetch_entry_t       wr_entry_s;
    fetch_entry_t       rd_entry_s;
    logic [ENTRY_W-1:0] rdata_s;

    // Status is decoded from the count register alone so StallF has no path back through inputs.
    assign valid_s = (count_r != CW'(0));
    assign full_s  = (count_r == CW'(DEPTH));
    assign pop_s   = valid_s & ~StallD;
    assign push_s  = PushF & (~full_s | pop_s);
    assign we_s    = push_s & ~FlushD & rst_n;

    assign wr_entry_s.pc    = PCF;
    assign wr_entry_s.instr = InstrF;

    fetch_buf_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (FlushD) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_entry_s = fetch_entry_t'(rdata_s);

    // Head presentation: stale array contents are masked while the queue is empty.
    always_comb begin
        InstrD   = NOP_INSTR;
        PCPlus1D = PC_W'(0);
        if (valid_s) begin
            InstrD   = rd_entry_s.instr;
            PCPlus1D = pc_inc(rd_entry_s.pc);
        end else begin
            InstrD   = NOP_INSTR;
            PCPlus1D = PC_W'(0);
        end
    end

    assign ValidD   = valid_s;
    assign BufFullF = full_s;
    assign CountF   = count_r;

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue model of accepted words is checked against the head outputs.
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [6:0]  pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  PCF = 7'd0;
    logic [31:0] InstrF = 32'd0;
    logic        PushF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [31:0] InstrD;
    logic [6:0]  PCPlus1D;
    logic        ValidD;
    logic        BufFullF;
    logic [2:0]  CountF;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PCF      (PCF),
        .InstrF   (InstrF),
        .PushF    (PushF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .InstrD   (InstrD),
        .PCPlus1D (PCPlus1D),
        .ValidD   (ValidD),
        .BufFullF (BufFullF),
        .CountF   (CountF)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: mid-cycle, compare the presented head against the model and retire it when decode takes it.
    always @(negedge clk) begin
        if (mon_en) begin
            int   n;
            ent_t e;
            n = exp_q.size();
            chk("count", 64'(CountF), 64'(n));
            chk("full", 64'(BufFullF), 64'(n == DEPTH));
            chk("valid", 64'(ValidD), 64'(n != 0));
            if (n != 0) begin
                e = exp_q[0];
                chk("instr", 64'(InstrD), 64'(e.instr));
                chk("pcplus1", 64'(PCPlus1D), 64'((int'(e.pc) + 1) % 128));
                if (!StallD) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("instr_nop", 64'(InstrD), 64'd0);
                chk("pcplus1_zero", 64'(PCPlus1D), 64'd0);
            end
        end
    end

    // One clock of stimulus; the model absorbs the accepted word at the edge.
    task automatic cyc(input bit p, input logic [6:0] pc, input logic [31:0] ins,
                       input bit st, input bit fl, input bit rs);
        PushF  = p;
        PCF    = pc;
        InstrF = ins;
        StallD = st;
        FlushD = fl;
        rst_n  = ~rs;
        @(posedge clk);
        if (rs || fl) begin
            exp_q.delete();
        end else if (p && exp_q.size() < DEPTH) begin
            exp_q.push_back('{pc: pc, instr: ins});
        end
        #1;
    endtask

    task automatic idle(input bit st, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 7'd0, 32'd0, st, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset and idle
        cyc(1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        cyc(1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 2);

        // Fill with decode stalled, fifth word dropped, then drain
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 7'(8'h10 + i), 32'(32'hA0 + i), 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1, 1);
        idle(1'b0, 6);

        // Streaming through a full buffer
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 7'(8'h40 + i), 32'(32'hB0 + i), 1'b1, 1'b0, 1'b0);
        end
        for (int i = 4; i < 12; i++) begin
            cyc(1'b1, 7'(8'h40 + i), 32'(32'hB0 + i), 1'b0, 1'b0, 1'b0);
        end
        idle(1'b0, 6);

        // Flush with a simultaneous push, then a right-path push
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 7'(8'h08 + i), 32'(32'hC0 + i), 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b1, 7'h20, 32'hDEAD_0020, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 7'h30, 32'hBEEF_0030, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1);
        idle(1'b0, 3);

        // PC wrap at the top of the address space, then pointer wrap
        cyc(1'b1, 7'h7F, 32'h1234_007F, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 7'(i), 32'(32'hE0 + i), 1'b0, 1'b0, 1'b0);
        end
        idle(1'b0, 3);

        // Reset mid-operation with a push in the same cycle
        cyc(1'b1, 7'h50, 32'hF050, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 7'h51, 32'hF051, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 7'h52, 32'hF052, 1'b1, 1'b0, 1'b1);
        idle(1'b0, 2);
        cyc(1'b1, 7'h60, 32'hF060, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 7, 7'($urandom), $urandom,
                $urandom_range(0, 9) < 4, $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 2);
        end

        idle(1'b0, DEPTH + 2);
        chk("final_valid", 64'(ValidD), 64'd0);
        chk("final_count", 64'(CountF), 64'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch buffer between the fetch stage (PC register plus combinational instruction ROM) and the decode stage of the pipelined CPU. Each cycle it accepts the fetched word and its PC and queues up to DEPTH entries. It presents the oldest entry to decode and raises a full flag that the hazard unit folds into StallF. A decode-side flush, caused by a taken branch or jump, discards everything queued.

## Interface
- DEPTH, 4: queue entries; power of two, 2..8.
- PC_W, 7: PC width (word address).
- INSTR_W, 32: instruction width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- PCF  in  PC_W  PC of the word fetched this cycle.
- InstrF  in  INSTR_W  ROM output for PCF.
- PushF  in  1  fetch produced a valid word this cycle (driven by ~StallF from the hazard unit).
- StallD  in  1  decode cannot consume this cycle.
- FlushD  in  1  discard all queued and incoming words.
- InstrD  out  INSTR_W  head instruction; NOP_INSTR when ValidD=0.
- PCPlus1D  out  PC_W  head PC + 1, modulo 2^PC_W; 0 when ValidD=0.
- ValidD  out  1  head entry present.
- BufFullF  out  1  count == DEPTH; feeds the StallF OR term.
- CountF  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Storage: DEPTH entries of {PC, instr}. Read pointer rd_ptr and write pointer wr_ptr are each $clog2(DEPTH) bits and wrap naturally. Occupancy is held in a separate count register.
- pop = ValidD & ~StallD.
- push = PushF & (~BufFullF | pop). A push while full is accepted only when a pop happens in the same cycle; otherwise it is dropped. The hazard unit guarantees this drop never happens in correct operation.
- Count update: push and no pop → +1; pop and no push → −1; both → unchanged, with both pointers advancing.
- FlushD has absolute priority over push and pop:
  - next cycle: count=0, rd_ptr=wr_ptr=0, ValidD=0;
  - the same-cycle PushF word is discarded as wrong-path.
- Head outputs are combinational from the registered storage and rd_ptr; no input feeds an output combinationally.
  - ValidD = (count != 0).
  - InstrD = mem[rd_ptr].instr when valid, else NOP_INSTR.
  - PCPlus1D = mem[rd_ptr].pc + 1 when valid, else 0. At PC 7'h7F it wraps to 7'h00.
- BufFullF and CountF are decoded from the count register only, so there is no combinational loop through StallF.
- Reset (rst_n=0 at a clk edge) overrides FlushD, push and pop:
  - count=0, pointers=0, ValidD=0, InstrD=NOP_INSTR, PCPlus1D=0, BufFullF=0, CountF=0;
  - storage contents are don't-care.
- Reset asserted mid-operation loses all queued entries; the first post-reset push is treated as into an empty buffer.

## Timing
- Latency: a word pushed at edge N into an empty buffer is visible on InstrD/ValidD after edge N, i.e. in cycle N+1. There is no combinational bypass.
- Throughput: 1 word/cycle in steady state, with simultaneous push and pop at any occupancy including full.
- BufFullF rises in the cycle after the DEPTH-th push. It falls in the cycle after a pop with no push.
- FlushD sampled at edge N gives ValidD=0 in cycle N+1. A PushF at edge N+1 is visible in cycle N+2.
- StallD held high: head outputs stay stable and pushes continue until full.

## Structure
- Shared package pcpu_pkg holds:
  - PC_W and INSTR_W constants;
  - NOP_INSTR = 32'h0000_0000;
  - fetch_entry_t = {pc[PC_W-1:0], instr[INSTR_W-1:0]}.
- One sub-module, fetch_buf_mem:
  - DEPTH×entry register array with synchronous write (we, waddr, wdata);
  - asynchronous read port (raddr → rdata);
  - no reset on the array.
- Pointers, count, push/pop/flush control and output muxing live in fetch_buffer.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, release → ValidD=0, InstrD=0, PCPlus1D=0, BufFullF=0, CountF=0.
- Fill and drain: StallD=1; push PCs 0x10..0x13 with instrs 0xA0..0xA3 → CountF=4 and BufFullF=1 after the 4th push; a 5th push is dropped. Release StallD → InstrD = A0, A1, A2, A3 on consecutive cycles; PCPlus1D = 0x11..0x14; then ValidD=0.
- Streaming at full: buffer full with StallD=0 and PushF=1 every cycle → CountF stays 4, BufFullF stays 1, one word per cycle in order, no loss.
- Flush with simultaneous push: 3 entries queued; assert FlushD and PushF (PC 0x20) in the same cycle → next cycle ValidD=0, CountF=0. Then push PC 0x30 → InstrD shows the 0x30 word one cycle later with PCPlus1D=0x31.
- Wrap-around: push PC 0x7F → PCPlus1D=0x00. Run 10 push/pop cycles so the pointers wrap twice → output order stays intact.
- Reset mid-operation: 2 entries queued with PushF=1 and FlushD=0; assert rst_n=0 for one edge → all outputs return to reset values, and the pushed word is not retained.
